// File: rtl/alu_seq_exec_if.sv
// Handshake and operand/result bundle between the decode stage and alu_seq_exec.
interface alu_seq_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             done;

  modport master (
    output in_valid, ctrl, a, b, shamt,
    input  in_ready, result, zero, illegal, done
  );

  modport slave (
    input  in_valid, ctrl, a, b, shamt,
    output in_ready, result, zero, illegal, done
  );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle logic/arithmetic ops, iterative SLL
// (one bit per cycle), registered result with done/zero/illegal flags.
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_exec_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_JR  = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1111;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_is_sll;
  logic             w_shift_fin;
  logic [WIDTH:0]   w_alu;

  // Returns {illegal, result}; SLL never reaches here because it takes the shift path.
  function automatic logic [WIDTH:0] alu_eval(input logic [3:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    sx = x;
    sy = y;
    case (op)
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_ADD:  return {1'b0, x + y};
      OP_SUB:  return {1'b0, x - y};
      OP_SLT:  return {1'b0, {(WIDTH-1){1'b0}}, (sx < sy)};
      OP_JR:   return {1'b0, x};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  assign w_is_sll = (bus.ctrl == OP_SLL);
  assign w_accept = bus.in_valid & w_ready;
  assign w_alu    = alu_eval(bus.ctrl, bus.a, bus.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_sll) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0)          w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = (r_state == S_IDLE);
    w_shift_fin = (r_state == S_SHIFT) && (r_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && w_is_sll) begin
        r_sh  <= bus.b;
        r_cnt <= bus.shamt;
      end else if (w_accept) begin
        r_result  <= w_alu[WIDTH-1:0];
        r_zero    <= (w_alu[WIDTH-1:0] == '0);
        r_illegal <= w_alu[WIDTH];
        r_done    <= 1'b1;
      end else if (w_shift_fin) begin
        r_result  <= r_sh;
        r_zero    <= (r_sh == '0);
        r_illegal <= 1'b0;
        r_done    <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt - SHW'(1);
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.illegal  = r_illegal;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_seq_exec_if #(.WIDTH(32), .SHW(5)) bus ();
  alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                         input logic [31:0] y);
    if (c == 4'b0000) return {1'b0, x & y};
    if (c == 4'b0001) return {1'b0, x | y};
    if (c == 4'b0010) return {1'b0, x + y};
    if (c == 4'b0110) return {1'b0, x - y};
    if (c == 4'b0111) return ($signed(x) < $signed(y)) ? 33'd1 : 33'd0;
    if (c == 4'b1000) return {1'b0, x};
    return {1'b1, 32'd0};
  endfunction

  // Model: m_left counts clock edges until a pending SLL completes.
  int          m_left   = 0;
  logic        m_done   = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic        m_zero   = 1'b1;
  logic        m_ill    = 1'b0;
  logic [31:0] m_pend   = 32'd0;
  logic [32:0] m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_result = 32'd0; m_zero = 1'b1; m_ill = 1'b0; m_pend = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_pend; m_zero = (m_pend == 32'd0); m_ill = 1'b0; m_done = 1'b1;
        end
      end else if (bus.in_valid) begin
        if (bus.ctrl == 4'b1111) begin
          m_pend = bus.b << bus.shamt;
          m_left = int'(bus.shamt) + 1;
        end else begin
          m_tmp    = ref_op(bus.ctrl, bus.a, bus.b);
          m_result = m_tmp[31:0]; m_ill = m_tmp[32]; m_zero = (m_tmp[31:0] == 32'd0);
          m_done   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_in_ready", {31'd0, bus.in_ready}, {31'd0, m_left == 0});
    check("mdl_done",     {31'd0, bus.done},     {31'd0, m_done});
    check("mdl_result",   bus.result,            m_result);
    check("mdl_zero",     {31'd0, bus.zero},     {31'd0, m_zero});
    check("mdl_illegal",  {31'd0, bus.illegal},  {31'd0, m_ill});
  end

  task automatic op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                    input logic [4:0] s, output int rej);
    bus.in_valid = 1'b1; bus.ctrl = c; bus.a = x; bus.b = y; bus.shamt = s;
    rej = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      rej++;
    end
    if (rej >= 100) check("accept_timeout", 32'(rej), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_done(input string name, input logic [31:0] res, input logic z,
                             input logic ill, input int lat);
    int k;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      k = i;
      if (bus.done) break;
    end
    check({name, "_lat"},     32'(k),                 32'(lat));
    check({name, "_result"},  bus.result,             res);
    check({name, "_zero"},    {31'd0, bus.zero},      {31'd0, z});
    check({name, "_illegal"}, {31'd0, bus.illegal},   {31'd0, ill});
    @(posedge clk); #1;
  endtask

  int rej;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.ctrl = 4'd0; bus.a = 32'd0; bus.b = 32'd0; bus.shamt = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result",   bus.result,            32'd0);
    check("rst_zero",     {31'd0, bus.zero},     32'd1);
    check("rst_illegal",  {31'd0, bus.illegal},  32'd0);
    check("rst_done",     {31'd0, bus.done},     32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;

    op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, rej);
    expect_done("add", 32'h8000_0000, 1'b0, 1'b0, 1);
    op(4'b0110, 32'd5, 32'd5, 5'd0, rej);
    expect_done("sub", 32'd0, 1'b1, 1'b0, 1);
    op(4'b0001, 32'h0F00_00F0, 32'h00F0_000F, 5'd0, rej);
    expect_done("or", 32'h0FF0_00FF, 1'b0, 1'b0, 1);

    // Back-to-back SLTs: done in two consecutive cycles.
    bus.in_valid = 1'b1; bus.ctrl = 4'b0111; bus.a = 32'hFFFF_FFFF; bus.b = 32'd1;
    @(posedge clk); #1;
    bus.a = 32'd1; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    check("slt1_done",   {31'd0, bus.done}, 32'd1);
    check("slt1_result", bus.result,        32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("slt2_done",   {31'd0, bus.done}, 32'd1);
    check("slt2_result", bus.result,        32'd0);
    @(posedge clk); #1;

    op(4'b1111, 32'h1234_5678, 32'h0000_0003, 5'd4, rej);
    expect_done("sll4", 32'h0000_0030, 1'b0, 1'b0, 6);
    op(4'b1111, 32'd0, 32'hDEAD_BEEF, 5'd0, rej);
    expect_done("sll0", 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    op(4'b1111, 32'd0, 32'h8000_0000, 5'd1, rej);
    expect_done("sll_out", 32'd0, 1'b1, 1'b0, 3);
    op(4'b1111, 32'd0, 32'h0000_0001, 5'd31, rej);
    expect_done("sll31", 32'h8000_0000, 1'b0, 1'b0, 33);

    // AND held during an SLL must wait until in_ready rises.
    op(4'b1111, 32'd0, 32'h0000_0003, 5'd4, rej);
    op(4'b0000, 32'h0000_00F0, 32'h0000_003C, 5'd0, rej);
    check("busy_rejects", 32'(rej), 32'd5);
    expect_done("and_busy", 32'h0000_0030, 1'b0, 1'b0, 1);

    op(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, rej);
    expect_done("illegal", 32'd0, 1'b1, 1'b1, 1);
    op(4'b1000, 32'h0040_0020, 32'h1111_1111, 5'd0, rej);
    expect_done("jr", 32'h0040_0020, 1'b0, 1'b0, 1);

    // Reset during SLL shamt=10 at cycle N+3.
    op(4'b1111, 32'd0, 32'h0000_0005, 5'd10, rej);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_result",   bus.result,            32'd0);
    check("mid_rst_zero",     {31'd0, bus.zero},     32'd1);
    check("mid_rst_illegal",  {31'd0, bus.illegal},  32'd0);
    check("mid_rst_done",     {31'd0, bus.done},     32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("no_done_after_rst", {31'd0, bus.done}, 32'd0);
    end
    @(posedge clk); #1;
    op(4'b0010, 32'd2, 32'd2, 5'd0, rej);
    expect_done("add_post_rst", 32'd4, 1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
